speck_block_engine: RTL

Iterative, parametrised Speck block-cipher engine performing full encryption or decryption of one block per request, selectable per block. It expands a loaded master key into an internal round-key file once, then runs T rounds of a single shared forward/inverse round datapath, one round per clock. It sits between the UART framing logic and the key/data registers, replacing per-round combinational instances with a complete cipher core.

---
 rtl/speck_pkg.sv | 49 ++++
 rtl/speck_block_engine_round.sv | 30 +++
 rtl/speck_block_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/speck_pkg.sv
// Speck block engine shared types and helpers.
// Rotates operate on the low w bits of a 64-bit carrier.
package speck_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEYGEN,
    S_READY,
    S_RUN,
    S_DONE
  } state_e;

  localparam int SPECK64_128_W = 32;
  localparam int SPECK64_128_M = 4;
  localparam int SPECK64_128_T = 27;
  localparam int SPECK64_128_A = 8;
  localparam int SPECK64_128_B = 3;

  localparam int SPECK32_64_W = 16;
  localparam int SPECK32_64_M = 4;
  localparam int SPECK32_64_T = 22;
  localparam int SPECK32_64_A = 7;
  localparam int SPECK32_64_B = 2;

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] rol(
    input logic [63:0] v,
    input int          w,
    input int          s
  );
    logic [63:0] m;
    m = wmask(w);
    return ((v << s) | ((v & m) >> (w - s))) & m;
  endfunction

  function automatic logic [63:0] ror(
    input logic [63:0] v,
    input int          w,
    input int          s
  );
    logic [63:0] m;
    m = wmask(w);
    return (((v & m) >> s) | (v << (w - s))) & m;
  endfunction

endpackage

// File: rtl/speck_block_engine_round.sv
// One Speck round, forward or inverse.
// Also drives the key schedule update (l as x, rk as y, i as k).
module speck_round_dual
  import speck_pkg::*;
#(
  parameter int W     = 32,
  parameter int ALPHA = 8,
  parameter int BETA  = 3
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] k,
  input  logic         mode,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out
);

  logic [W-1:0] xe, ye, xd, yd;

  // forward and inverse round, selected by mode
  always_comb begin
    xe    = (W'(ror(64'(x), W, ALPHA)) + y) ^ k;
    ye    = W'(rol(64'(y), W, BETA)) ^ xe;
    yd    = W'(ror(64'(x ^ y), W, BETA));
    xd    = W'(rol(64'((x ^ k) - yd), W, ALPHA));
    x_out = mode ? xd : xe;
    y_out = mode ? yd : ye;
  end

endmodule

// File: rtl/speck_block_engine.sv
// Iterative Speck engine: key expansion into a round-key
// file, then one shared round per clock for enc/dec.
module speck_block_engine
  import speck_pkg::*;
#(
  parameter int W     = SPECK64_128_W,
  parameter int M     = SPECK64_128_M,
  parameter int T     = SPECK64_128_T,
  parameter int ALPHA = SPECK64_128_A,
  parameter int BETA  = SPECK64_128_B
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_valid,
  output logic           key_ready,
  input  logic [M*W-1:0] key_in,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_mode,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_x,
  output logic [W-1:0]   out_y,
  output logic           out_mode,
  output logic           key_loaded
);

  localparam int CW = $clog2(T);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic [W-1:0]  kc_q, kc_d;
  logic          mode_q, mode_d;
  logic          ld_q, ld_d;
  logic [W-1:0]  l_q [M-1];
  logic [W-1:0]  l_d [M-1];
  logic [W-1:0]  rk_q [T];

  logic          rk_we;
  logic [CW-1:0] rk_wa;
  logic [W-1:0]  rk_wd;
  logic [CW-1:0] rd_idx;
  logic [W-1:0]  rd_k;
  logic [W-1:0]  rx, ry, rkk, nx, ny;
  logic          rmode;
  logic          key_hs, in_hs;

  assign key_ready  = (state_q == S_IDLE) ||
                      (state_q == S_READY);
  assign in_ready   = (state_q == S_READY) && !key_valid;
  assign out_valid  = (state_q == S_DONE);
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign out_mode   = mode_q;
  assign key_loaded = ld_q;

  assign key_hs = key_valid && key_ready;
  assign in_hs  = in_valid && in_ready;
  assign rd_idx = mode_q ? (CW'(T - 1) - cnt_q) : cnt_q;
  assign rd_k   = rk_q[rd_idx];

  // share the round datapath between key schedule and data
  always_comb begin
    rx    = x_q;
    ry    = y_q;
    rkk   = rd_k;
    rmode = mode_q;
    if (state_q == S_KEYGEN) begin
      rx    = l_q[0];
      ry    = kc_q;
      rkk   = W'(cnt_q);
      rmode = 1'b0;
    end
  end

  speck_round_dual #(
    .W    (W),
    .ALPHA(ALPHA),
    .BETA (BETA)
  ) u_round (
    .x    (rx),
    .y    (ry),
    .k    (rkk),
    .mode (rmode),
    .x_out(nx),
    .y_out(ny)
  );

  // next state, datapath updates and key-file write
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    kc_d    = kc_q;
    mode_d  = mode_q;
    ld_d    = ld_q;
    l_d     = l_q;
    rk_we   = 1'b0;
    rk_wa   = cnt_q + 1'b1;
    rk_wd   = ny;
    case (state_q)
      S_IDLE, S_READY: begin
        if (key_hs) begin
          state_d = S_KEYGEN;
          cnt_d   = '0;
          ld_d    = 1'b0;
          kc_d    = key_in[W-1:0];
          rk_we   = 1'b1;
          rk_wa   = '0;
          rk_wd   = key_in[W-1:0];
          for (int j = 0; j < M - 1; j++)
            l_d[j] = key_in[(j+1)*W +: W];
        end else if (in_hs) begin
          state_d = S_RUN;
          cnt_d   = '0;
          x_d     = in_x;
          y_d     = in_y;
          mode_d  = in_mode;
        end
      end
      S_KEYGEN: begin
        rk_we = 1'b1;
        kc_d  = ny;
        for (int j = 0; j < M - 2; j++)
          l_d[j] = l_q[j+1];
        l_d[M-2] = nx;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(T - 2)) begin
          state_d = S_READY;
          ld_d    = 1'b1;
        end
      end
      S_RUN: begin
        x_d   = nx;
        y_d   = ny;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(T - 1))
          state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      kc_q    <= '0;
      mode_q  <= 1'b0;
      ld_q    <= 1'b0;
      for (int j = 0; j < M - 1; j++)
        l_q[j] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      kc_q    <= kc_d;
      mode_q  <= mode_d;
      ld_q    <= ld_d;
      l_q     <= l_d;
    end
  end

  // round-key file; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (rk_we)
      rk_q[rk_wa] <= rk_wd;
  end

endmodule
